// File: rtl/peripheral_ahb4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_ahb4_pkg
// Description : Shared AHB4-Lite encodings, byte-lane helpers and the
//               interrupt-controller register map.
// Revision    : 1.0 - initial release
// ============================================================================
package peripheral_ahb4_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Interrupt-controller registers, encoded as word index HADDR[4:2]
    typedef enum logic [2:0] {
        INTC_CONFIG    = 3'd0,
        INTC_IENABLE   = 3'd1,
        INTC_IPENDING  = 3'd2,
        INTC_CLAIM     = 3'd3,
        INTC_INSERVICE = 3'd4
    } intc_reg_e;

    localparam int INTC_ID_W = 5;

    function automatic logic [3:0] ahb_byte_en(input logic [2:0] hsize,
                                               input logic [1:0] addr);
        logic [3:0] be;
        case (hsize)
            HSIZE_BYTE:  be = 4'b0001 << addr;
            HSIZE_HWORD: be = addr[1] ? 4'b1100 : 4'b0011;
            default:     be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] ahb_be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/peripheral_intc_ahb4_if.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_intc_ahb4_if
// Description : AHB4-Lite slave bus bundle for the interrupt controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface peripheral_intc_ahb4_if #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32
);
    logic                  HSEL;
    logic [HADDR_SIZE-1:0] HADDR;
    logic [HDATA_SIZE-1:0] HWDATA;
    logic [HDATA_SIZE-1:0] HRDATA;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HREADYOUT;
    logic                  HREADY;
    logic                  HRESP;

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface
`default_nettype wire

// File: rtl/peripheral_intc_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_intc_prio_enc
// Description : Lowest-index-first priority encoder; o_id = index+1, 0 = none.
// Revision    : 1.0 - initial release
// ============================================================================
module peripheral_intc_prio_enc
    import peripheral_ahb4_pkg::*;
#(
    parameter int SOURCES = 8
) (
    input  wire logic [SOURCES-1:0]   i_req,
    output logic      [INTC_ID_W-1:0] o_id
);

    // Scan downward so the lowest set index is the last one written
    always_comb begin
        o_id = '0;
        for (int i = SOURCES - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_id = INTC_ID_W'(i + 1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/peripheral_intc_ahb4.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_intc_ahb4
// Description : Zero-wait AHB4-Lite interrupt controller with claim/complete.
// Revision    : 1.0 - initial release
// ============================================================================
module peripheral_intc_ahb4
    import peripheral_ahb4_pkg::*;
#(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int SOURCES    = 8
) (
    input  wire logic               HCLK,
    input  wire logic               HRESETn,
    peripheral_intc_ahb4_if.slave   ahb,
    input  wire logic [SOURCES-1:0] src,
    output logic                    irq
);

    logic                  w_valid;
    logic                  w_rd_claim;
    logic [HDATA_SIZE-1:0] w_rdata;
    logic [HDATA_SIZE-1:0] w_wmask;
    logic [HDATA_SIZE-1:0] w_wdata;
    logic                  w_wr_config;
    logic                  w_wr_ienable;
    logic                  w_wr_ipending;
    logic                  w_wr_claim;
    logic [SOURCES-1:0]    w_eligible;
    logic [SOURCES-1:0]    w_set;
    logic [SOURCES-1:0]    w_claim_oh;
    logic [SOURCES-1:0]    w_cmpl_oh;
    logic [SOURCES-1:0]    w_w1c;
    logic [INTC_ID_W-1:0]  w_id;
    logic                  w_unused;

    logic                  r_we;
    logic [2:0]            r_addr;
    logic [3:0]            r_be;
    logic [HDATA_SIZE-1:0] r_hrdata;
    logic [SOURCES-1:0]    r_config;
    logic [SOURCES-1:0]    r_ienable;
    logic [SOURCES-1:0]    r_pending;
    logic [SOURCES-1:0]    r_inservice;
    logic [SOURCES-1:0]    r_src_d;
    logic                  r_irq;

    assign ahb.HREADYOUT = 1'b1;
    assign ahb.HRESP     = HRESP_OKAY;
    assign ahb.HRDATA    = r_hrdata;
    assign irq           = r_irq;

    assign w_unused = ^{ahb.HBURST, ahb.HPROT, ahb.HADDR[HADDR_SIZE-1:5]};

    assign w_valid = ahb.HREADY & ahb.HSEL &
                     ((ahb.HTRANS == HTRANS_NONSEQ) | (ahb.HTRANS == HTRANS_SEQ));

    // Data-phase write path, lanes limited by the captured byte enables
    assign w_wmask       = ahb_be_mask(r_be);
    assign w_wdata       = ahb.HWDATA & w_wmask;
    assign w_wr_config   = r_we & (r_addr == INTC_CONFIG);
    assign w_wr_ienable  = r_we & (r_addr == INTC_IENABLE);
    assign w_wr_ipending = r_we & (r_addr == INTC_IPENDING);
    assign w_wr_claim    = r_we & (r_addr == INTC_CLAIM);
    assign w_w1c         = w_wr_ipending ? w_wdata[SOURCES-1:0] : '0;

    assign w_eligible = r_pending & r_ienable & ~r_inservice;

    peripheral_intc_prio_enc #(
        .SOURCES (SOURCES)
    ) u_prio_enc (
        .i_req (w_eligible),
        .o_id  (w_id)
    );

    assign w_rd_claim = w_valid & ~ahb.HWRITE & (ahb.HADDR[4:2] == INTC_CLAIM) &
                        (w_id != '0);

    generate
        for (genvar g = 0; g < SOURCES; g++) begin : g_src
            assign w_set[g]      = r_config[g] ? (src[g] & ~r_src_d[g]) : src[g];
            assign w_claim_oh[g] = w_rd_claim & (w_id == INTC_ID_W'(g + 1));
            assign w_cmpl_oh[g]  = w_wr_claim & r_inservice[g] &
                                   (w_wdata == HDATA_SIZE'(g + 1));
        end
    endgenerate

    always_comb begin
        w_rdata = '0;
        case (ahb.HADDR[4:2])
            INTC_CONFIG:    w_rdata = HDATA_SIZE'(r_config);
            INTC_IENABLE:   w_rdata = HDATA_SIZE'(r_ienable);
            INTC_IPENDING:  w_rdata = HDATA_SIZE'(r_pending);
            INTC_CLAIM:     w_rdata = HDATA_SIZE'(w_id);
            INTC_INSERVICE: w_rdata = HDATA_SIZE'(r_inservice);
            default:        w_rdata = '0;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_be        <= '0;
            r_hrdata    <= '0;
            r_config    <= '0;
            r_ienable   <= '0;
            r_pending   <= '0;
            r_inservice <= '0;
            r_src_d     <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_we    <= w_valid & ahb.HWRITE;
            r_src_d <= src;
            r_irq   <= |w_eligible;
            if (w_valid) begin
                r_addr <= ahb.HADDR[4:2];
                r_be   <= ahb_byte_en(ahb.HSIZE, ahb.HADDR[1:0]);
            end
            if (w_valid & ~ahb.HWRITE) begin
                r_hrdata <= w_rdata;
            end
            if (w_wr_config) begin
                r_config <= (r_config & ~w_wmask[SOURCES-1:0]) | w_wdata[SOURCES-1:0];
            end
            if (w_wr_ienable) begin
                r_ienable <= (r_ienable & ~w_wmask[SOURCES-1:0]) | w_wdata[SOURCES-1:0];
            end
            // A new request in the same cycle beats any clear of that bit
            r_pending   <= (r_pending & ~(w_claim_oh | w_w1c)) | w_set;
            r_inservice <= (r_inservice & ~w_cmpl_oh) | w_claim_oh;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_peripheral_intc_ahb4.sv
`default_nettype none
// ============================================================================
// Module      : tb_peripheral_intc_ahb4
// Description : Self-checking bench for the AHB4-Lite interrupt controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_peripheral_intc_ahb4;
    import peripheral_ahb4_pkg::*;

    localparam int c_SOURCES = 8;
    localparam logic [31:0] A_CONFIG = 32'h00, A_IENABLE = 32'h04, A_IPENDING = 32'h08,
                            A_CLAIM = 32'h0C, A_INSERVICE = 32'h10;

    logic                 HCLK = 1'b0;
    logic                 HRESETn = 1'b0;
    logic [c_SOURCES-1:0] src = '0;
    logic                 irq;

    int n_checks = 0;
    int n_fail   = 0;

    string       name_q[$];
    logic [31:0] exp_q[$];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  size;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[20];

    peripheral_intc_ahb4_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) ahb ();

    peripheral_intc_ahb4 #(
        .HADDR_SIZE (32),
        .HDATA_SIZE (32),
        .SOURCES    (c_SOURCES)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .ahb     (ahb),
        .src     (src),
        .irq     (irq)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        ahb.HSEL   = 1'b0;
        ahb.HTRANS = HTRANS_IDLE;
        ahb.HWRITE = 1'b0;
    endtask

    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [2:0] size);
        ahb.HSEL   = 1'b1;
        ahb.HTRANS = HTRANS_NONSEQ;
        ahb.HWRITE = 1'b1;
        ahb.HADDR  = addr;
        ahb.HSIZE  = size;
        @(posedge HCLK); #1;
        bus_idle();
        ahb.HWDATA = data;
        @(posedge HCLK); #1;
    endtask

    // Expected value is queued at issue and retired when HRDATA is presented
    task automatic ahb_read(input logic [31:0] addr, input string name,
                            input logic [31:0] exp);
        name_q.push_back(name);
        exp_q.push_back(exp);
        ahb.HSEL   = 1'b1;
        ahb.HTRANS = HTRANS_NONSEQ;
        ahb.HWRITE = 1'b0;
        ahb.HADDR  = addr;
        ahb.HSIZE  = HSIZE_WORD;
        @(posedge HCLK); #1;
        bus_idle();
        check(name_q.pop_front(), ahb.HRDATA, exp_q.pop_front());
    endtask

    task automatic pulse_src(input logic [c_SOURCES-1:0] v);
        src = v;
        @(posedge HCLK); #1;
        src = '0;
    endtask

    initial begin
        vecs[0]  = '{1'b0, A_CONFIG,    32'h0,        HSIZE_WORD,  32'h0};
        vecs[1]  = '{1'b0, A_IENABLE,   32'h0,        HSIZE_WORD,  32'h0};
        vecs[2]  = '{1'b0, A_IPENDING,  32'h0,        HSIZE_WORD,  32'h0};
        vecs[3]  = '{1'b0, A_CLAIM,     32'h0,        HSIZE_WORD,  32'h0};
        vecs[4]  = '{1'b0, A_INSERVICE, 32'h0,        HSIZE_WORD,  32'h0};
        vecs[5]  = '{1'b1, A_CONFIG,    32'hFFFFFFFF, HSIZE_WORD,  32'h0};
        vecs[6]  = '{1'b0, A_CONFIG,    32'h0,        HSIZE_WORD,  32'hFF};
        vecs[7]  = '{1'b1, A_IENABLE,   32'h12345678, HSIZE_WORD,  32'h0};
        vecs[8]  = '{1'b0, A_IENABLE,   32'h0,        HSIZE_WORD,  32'h78};
        vecs[9]  = '{1'b1, 32'h05,      32'h0000AA00, HSIZE_BYTE,  32'h0};
        vecs[10] = '{1'b0, A_IENABLE,   32'h0,        HSIZE_WORD,  32'h78};
        vecs[11] = '{1'b1, 32'h04,      32'hFFFFFF0F, HSIZE_BYTE,  32'h0};
        vecs[12] = '{1'b0, A_IENABLE,   32'h0,        HSIZE_WORD,  32'h0F};
        vecs[13] = '{1'b1, 32'h02,      32'h00FF0000, HSIZE_HWORD, 32'h0};
        vecs[14] = '{1'b0, A_CONFIG,    32'h0,        HSIZE_WORD,  32'hFF};
        vecs[15] = '{1'b1, A_CONFIG,    32'hFFFF0003, HSIZE_HWORD, 32'h0};
        vecs[16] = '{1'b0, A_CONFIG,    32'h0,        HSIZE_WORD,  32'h03};
        vecs[17] = '{1'b1, 32'h14,      32'hFFFFFFFF, HSIZE_WORD,  32'h0};
        vecs[18] = '{1'b0, 32'h14,      32'h0,        HSIZE_WORD,  32'h0};
        vecs[19] = '{1'b0, 32'h1C,      32'h0,        HSIZE_WORD,  32'h0};

        ahb.HADDR  = '0;
        ahb.HWDATA = '0;
        ahb.HSIZE  = HSIZE_WORD;
        ahb.HBURST = 3'b000;
        ahb.HPROT  = 4'b0011;
        ahb.HREADY = 1'b1;
        bus_idle();
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;

        check("reset_irq", {31'd0, irq}, 32'd0);
        check("hreadyout", {31'd0, ahb.HREADYOUT}, 32'd1);
        check("hresp", {31'd0, ahb.HRESP}, {31'd0, HRESP_OKAY});
        check("reset_hrdata", ahb.HRDATA, 32'd0);

        // Register map, byte lanes and unmapped offsets
        for (int i = 0; i < 20; i++) begin
            if (vecs[i].we) ahb_write(vecs[i].addr, vecs[i].data, vecs[i].size);
            else            ahb_read(vecs[i].addr, $sformatf("vec%0d", i), vecs[i].exp);
        end
        ahb_write(A_INSERVICE, 32'hFF, HSIZE_WORD);
        ahb_read(A_INSERVICE, "inservice_ro", 32'h0);

        // Level source
        ahb_write(A_CONFIG, 32'h0, HSIZE_WORD);
        ahb_write(A_IENABLE, 32'h1, HSIZE_WORD);
        pulse_src(8'h01);
        check("lvl_irq_early", {31'd0, irq}, 32'd0);
        @(posedge HCLK); #1;
        check("lvl_irq", {31'd0, irq}, 32'd1);
        ahb_read(A_IPENDING, "lvl_pending", 32'h1);
        ahb_read(A_CLAIM, "lvl_claim", 32'd1);
        @(posedge HCLK); #1;
        check("lvl_irq_after_claim", {31'd0, irq}, 32'd0);
        ahb_read(A_INSERVICE, "lvl_inservice", 32'h1);
        ahb_read(A_IPENDING, "lvl_pending_clr", 32'h0);
        ahb_write(A_CLAIM, 32'd1, HSIZE_WORD);
        ahb_read(A_INSERVICE, "lvl_complete", 32'h0);

        // Edge source held high
        ahb_write(A_CONFIG, 32'h4, HSIZE_WORD);
        ahb_write(A_IENABLE, 32'h4, HSIZE_WORD);
        src = 8'h04;
        repeat (10) @(posedge HCLK);
        #1 src = '0;
        ahb_read(A_IPENDING, "edge_pending", 32'h4);
        ahb_read(A_CLAIM, "edge_claim1", 32'd3);
        ahb_read(A_CLAIM, "edge_claim2", 32'd0);
        ahb_write(A_CLAIM, 32'd3, HSIZE_WORD);
        ahb_read(A_INSERVICE, "edge_complete", 32'h0);

        // Priority
        ahb_write(A_CONFIG, 32'h2A, HSIZE_WORD);
        ahb_write(A_IENABLE, 32'h0A, HSIZE_WORD);
        pulse_src(8'h0A);
        ahb_read(A_CLAIM, "prio_claim1", 32'd2);
        ahb_read(A_CLAIM, "prio_claim2", 32'd4);
        ahb_read(A_INSERVICE, "prio_inservice", 32'h0A);
        ahb_write(A_CLAIM, 32'd2, HSIZE_WORD);
        ahb_write(A_CLAIM, 32'd4, HSIZE_WORD);
        ahb_read(A_INSERVICE, "prio_complete", 32'h0);

        // Nested request while in service
        ahb_write(A_CONFIG, 32'h1, HSIZE_WORD);
        ahb_write(A_IENABLE, 32'h1, HSIZE_WORD);
        pulse_src(8'h01);
        repeat (2) @(posedge HCLK);
        #1;
        ahb_read(A_CLAIM, "nest_claim", 32'd1);
        pulse_src(8'h01);
        ahb_read(A_IPENDING, "nest_pending", 32'h1);
        check("nest_irq_blocked", {31'd0, irq}, 32'd0);
        ahb_write(A_CLAIM, 32'd1, HSIZE_WORD);
        check("nest_irq_same", {31'd0, irq}, 32'd0);
        @(posedge HCLK); #1;
        check("nest_irq_next", {31'd0, irq}, 32'd1);
        ahb_read(A_CLAIM, "nest_reclaim", 32'd1);
        ahb_write(A_CLAIM, 32'd1, HSIZE_WORD);

        // Set vs W1C collision, then invalid completions
        ahb_write(A_CONFIG, 32'h20, HSIZE_WORD);
        ahb_write(A_IENABLE, 32'h0, HSIZE_WORD);
        pulse_src(8'h20);
        ahb_read(A_IPENDING, "coll_pending", 32'h20);
        ahb.HSEL   = 1'b1;
        ahb.HTRANS = HTRANS_NONSEQ;
        ahb.HWRITE = 1'b1;
        ahb.HADDR  = A_IPENDING;
        ahb.HSIZE  = HSIZE_WORD;
        @(posedge HCLK); #1;
        bus_idle();
        ahb.HWDATA = 32'h20;
        src        = 8'h20;
        @(posedge HCLK); #1;
        src = '0;
        ahb_read(A_IPENDING, "coll_set_wins", 32'h20);
        ahb_write(A_IPENDING, 32'h20, HSIZE_WORD);
        ahb_read(A_IPENDING, "w1c_clear", 32'h0);
        pulse_src(8'h20);
        ahb_write(A_IENABLE, 32'h20, HSIZE_WORD);
        ahb_read(A_CLAIM, "coll_claim", 32'd6);
        ahb_write(A_CLAIM, 32'd9, HSIZE_WORD);
        ahb_write(A_CLAIM, 32'd0, HSIZE_WORD);
        ahb_write(A_CLAIM, 32'd5, HSIZE_WORD);
        ahb_read(A_INSERVICE, "bad_complete", 32'h20);
        ahb_write(A_CLAIM, 32'd6, HSIZE_WORD);
        ahb_read(A_INSERVICE, "good_complete", 32'h0);

        // Reset during a claim read
        ahb_write(A_CONFIG, 32'h0, HSIZE_WORD);
        ahb_write(A_IENABLE, 32'h1, HSIZE_WORD);
        pulse_src(8'h01);
        ahb.HSEL   = 1'b1;
        ahb.HTRANS = HTRANS_NONSEQ;
        ahb.HWRITE = 1'b0;
        ahb.HADDR  = A_CLAIM;
        HRESETn    = 1'b0;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        bus_idle();
        check("rst_hrdata", ahb.HRDATA, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        ahb_read(A_CONFIG, "rst_config", 32'h0);
        ahb_read(A_IENABLE, "rst_ienable", 32'h0);
        ahb_read(A_IPENDING, "rst_pending", 32'h0);
        ahb_read(A_INSERVICE, "rst_inservice", 32'h0);
        check("rst_irq_later", {31'd0, irq}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
